// File: rtl/ic_cache_fsm.sv
// ic_cache_fsm: control FSM of a direct-mapped instruction cache.
// The cache has 512 lines of 128 bits. Tags and data live in external
// simple-dual-port RAMs. The valid bits are kept here.
// Build option: define IC_PRELOAD_EN to fetch PRELOAD_LINES lines from
// first_addr after reset. Without it, reset goes straight to IDLE and
// lines are filled only on misses.
//
// state   | meaning
// PRELOAD | fetch the initial run of lines over DMA
// IDLE    | wait for a pending fetch request
// LOOKUP  | wait out the RAM read latency, then compare tag and valid bit
// REFILL  | hold the DMA request until it is acked
// RESP    | write the refilled line; ic_data/cpu_read_ack are high this cycle
module ic_cache_fsm #(
    parameter int ADDR_W        = 33,
    parameter int DATA_W        = 128,
    parameter int INDEX_W       = 9,
    parameter int TAG_W         = 20,
    parameter int RAM_RD_LAT    = 2,
    parameter int PRELOAD_LINES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  cpu_read_addr,
    input  logic               cpu_read_valid,
    input  logic [ADDR_W-1:0]  first_addr,
    input  logic               ic_read_dma_ack,
    input  logic [DATA_W-1:0]  ic_read_dma_data,
    input  logic [TAG_W-1:0]   tag_doutb,
    input  logic [DATA_W-1:0]  ram_doutb,
    output logic [DATA_W-1:0]  ic_data,
    output logic               cpu_read_ack,
    output logic [ADDR_W-1:0]  ic_read_dma_addr,
    output logic               ic_read_dma_valid,
    output logic               tag_hit,
    output logic               tag_miss,
    output logic               tag_wea,
    output logic [INDEX_W-1:0] tag_addra,
    output logic [TAG_W-1:0]   tag_dina,
    output logic [INDEX_W-1:0] tag_addrb,
    output logic               ram_wea,
    output logic [INDEX_W-1:0] ram_addra,
    output logic [DATA_W-1:0]  ram_dina,
    output logic [INDEX_W-1:0] ram_addrb
);
    localparam int OFF_W  = ADDR_W - TAG_W - INDEX_W;
    localparam int LINE_W = ADDR_W - OFF_W;
    localparam int CNT_W  = (RAM_RD_LAT < 1) ? 1 : $clog2(RAM_RD_LAT + 1);

    typedef enum logic [2:0] {
        S_PRELOAD, S_IDLE, S_LOOKUP, S_REFILL, S_RESP
    } state_t;

`ifdef IC_PRELOAD_EN
    localparam state_t RST_STATE = (PRELOAD_LINES > 0) ? S_PRELOAD : S_IDLE;
    localparam int     PL_W      = (PRELOAD_LINES < 1) ? 1 : $clog2(PRELOAD_LINES + 1);
    logic [PL_W-1:0]   pl_left, pl_left_n;
    logic [LINE_W-1:0] pl_line, pl_line_n;
`else
    localparam state_t RST_STATE = S_IDLE;
`endif

    state_t                  state, state_n;
    logic                    pend_vld, pend_take;
    logic [LINE_W-1:0]       pend_line;
    logic [LINE_W-1:0]       cur_line, cur_line_n;
    logic [CNT_W-1:0]        lat_cnt, lat_cnt_n;
    logic [(1<<INDEX_W)-1:0] line_vld;
    logic                    set_vld;
    logic [INDEX_W-1:0]      set_idx;
    logic [INDEX_W-1:0]      cur_idx;
    logic [TAG_W-1:0]        cur_tag;
    logic [LINE_W-1:0]       dma_line;

    logic [DATA_W-1:0]       ic_data_n, wr_data_n;
    logic                    ack_n, hit_n, miss_n, dma_vld_n, wr_n;
    logic [ADDR_W-1:0]       dma_addr_n;
    logic [INDEX_W-1:0]      wr_idx_n, rd_idx_n;
    logic [TAG_W-1:0]        wr_tag_n;

    // byte offsets never matter; first_addr is unused without preload
    logic unused_bits;
    assign unused_bits = ^{cpu_read_addr[OFF_W-1:0], first_addr};

    assign cur_idx  = cur_line[INDEX_W-1:0];
    assign cur_tag  = cur_line[LINE_W-1:INDEX_W];
    assign dma_line = ic_read_dma_addr[ADDR_W-1:OFF_W];

    // one-deep pending request; a new strobe wins over the IDLE hand-off
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_line <= '0;
        end else if (cpu_read_valid) begin
            pend_vld  <= 1'b1;
            pend_line <= cpu_read_addr[ADDR_W-1:OFF_W];
        end else if (pend_take) begin
            pend_vld  <= 1'b0;
        end
    end

`ifdef IC_PRELOAD_EN
    // preload progress: lines left (down-counter) and line offset from first_addr
    always_ff @(posedge clk) begin
        if (rst) begin
            pl_left <= PL_W'(PRELOAD_LINES);
            pl_line <= '0;
        end else begin
            pl_left <= pl_left_n;
            pl_line <= pl_line_n;
        end
    end
`endif

    // next state and next values of every registered output
    always_comb begin
        state_n    = state;
        cur_line_n = cur_line;
        lat_cnt_n  = lat_cnt;
        pend_take  = 1'b0;
        set_vld    = 1'b0;
        set_idx    = cur_idx;
        ic_data_n  = ic_data;
        ack_n      = 1'b0;
        hit_n      = 1'b0;
        miss_n     = 1'b0;
        dma_vld_n  = ic_read_dma_valid;
        dma_addr_n = ic_read_dma_addr;
        wr_n       = 1'b0;
        wr_idx_n   = ram_addra;
        wr_tag_n   = tag_dina;
        wr_data_n  = ram_dina;
        rd_idx_n   = ram_addrb;
`ifdef IC_PRELOAD_EN
        pl_left_n  = pl_left;
        pl_line_n  = pl_line;
`endif
        case (state)
`ifdef IC_PRELOAD_EN
            S_PRELOAD: begin
                if (!ic_read_dma_valid) begin
                    dma_vld_n  = 1'b1;
                    dma_addr_n = {first_addr[ADDR_W-1:OFF_W] + pl_line, {OFF_W{1'b0}}};
                end else if (ic_read_dma_ack) begin
                    dma_vld_n = 1'b0;
                    wr_n      = 1'b1;
                    wr_idx_n  = dma_line[INDEX_W-1:0];
                    wr_tag_n  = dma_line[LINE_W-1:INDEX_W];
                    wr_data_n = ic_read_dma_data;
                    set_vld   = 1'b1;
                    set_idx   = dma_line[INDEX_W-1:0];
                    pl_line_n = pl_line + LINE_W'(1);
                    pl_left_n = pl_left - PL_W'(1);
                    if (pl_left == PL_W'(1)) state_n = S_IDLE;
                end
            end
`endif
            S_IDLE: begin
                if (pend_vld) begin
                    pend_take  = 1'b1;
                    cur_line_n = pend_line;
                    rd_idx_n   = pend_line[INDEX_W-1:0];
                    lat_cnt_n  = CNT_W'(RAM_RD_LAT);
                    state_n    = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (lat_cnt != '0) begin
                    lat_cnt_n = lat_cnt - CNT_W'(1);
                end else if (line_vld[cur_idx] && (tag_doutb == cur_tag)) begin
                    hit_n     = 1'b1;
                    ack_n     = 1'b1;
                    ic_data_n = ram_doutb;
                    state_n   = S_IDLE;
                end else begin
                    miss_n     = 1'b1;
                    dma_vld_n  = 1'b1;
                    dma_addr_n = {cur_line, {OFF_W{1'b0}}};
                    state_n    = S_REFILL;
                end
            end
            S_REFILL: begin
                if (ic_read_dma_ack) begin
                    dma_vld_n = 1'b0;
                    wr_n      = 1'b1;
                    wr_idx_n  = cur_idx;
                    wr_tag_n  = cur_tag;
                    wr_data_n = ic_read_dma_data;
                    ic_data_n = ic_read_dma_data;
                    ack_n     = 1'b1;
                    set_vld   = 1'b1;
                    state_n   = S_RESP;
                end
            end
            S_RESP:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // state, lookup context, valid bits and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= RST_STATE;
            cur_line          <= '0;
            lat_cnt           <= '0;
            line_vld          <= '0;
            ic_data           <= '0;
            cpu_read_ack      <= 1'b0;
            tag_hit           <= 1'b0;
            tag_miss          <= 1'b0;
            ic_read_dma_valid <= 1'b0;
            ic_read_dma_addr  <= '0;
            tag_wea           <= 1'b0;
            tag_addra         <= '0;
            tag_dina          <= '0;
            tag_addrb         <= '0;
            ram_wea           <= 1'b0;
            ram_addra         <= '0;
            ram_dina          <= '0;
            ram_addrb         <= '0;
        end else begin
            state             <= state_n;
            cur_line          <= cur_line_n;
            lat_cnt           <= lat_cnt_n;
            if (set_vld) line_vld[set_idx] <= 1'b1;
            ic_data           <= ic_data_n;
            cpu_read_ack      <= ack_n;
            tag_hit           <= hit_n;
            tag_miss          <= miss_n;
            ic_read_dma_valid <= dma_vld_n;
            ic_read_dma_addr  <= dma_addr_n;
            tag_wea           <= wr_n;
            tag_addra         <= wr_idx_n;
            tag_dina          <= wr_tag_n;
            tag_addrb         <= rd_idx_n;
            ram_wea           <= wr_n;
            ram_addra         <= wr_idx_n;
            ram_dina          <= wr_data_n;
            ram_addrb         <= rd_idx_n;
        end
    end
endmodule

// File: tb/tb_ic_cache_fsm.sv
// Bench for ic_cache_fsm: RAM models with 2-cycle read latency, a DMA
// responder, and a line-level cache model (valid + tag per index) that
// predicts hit/miss, latency and returned data for random fetches.
module tb_ic_cache_fsm;
    logic         clk = 1'b0;
    logic         rst;
    logic [32:0]  cpu_read_addr;
    logic         cpu_read_valid;
    logic [32:0]  first_addr;
    logic         ic_read_dma_ack;
    logic [127:0] ic_read_dma_data;
    logic [19:0]  tag_doutb;
    logic [127:0] ram_doutb;
    logic [127:0] ic_data;
    logic         cpu_read_ack;
    logic [32:0]  ic_read_dma_addr;
    logic         ic_read_dma_valid;
    logic         tag_hit, tag_miss;
    logic         tag_wea, ram_wea;
    logic [8:0]   tag_addra, tag_addrb, ram_addra, ram_addrb;
    logic [19:0]  tag_dina;
    logic [127:0] ram_dina;

    int total = 0;
    int bad   = 0;

    localparam logic [32:0] JUNK_ADDR = {20'hFFFFF, 9'd77, 4'h3};

    ic_cache_fsm dut (
        .clk(clk), .rst(rst),
        .cpu_read_addr(cpu_read_addr), .cpu_read_valid(cpu_read_valid),
        .first_addr(first_addr),
        .ic_read_dma_ack(ic_read_dma_ack), .ic_read_dma_data(ic_read_dma_data),
        .tag_doutb(tag_doutb), .ram_doutb(ram_doutb),
        .ic_data(ic_data), .cpu_read_ack(cpu_read_ack),
        .ic_read_dma_addr(ic_read_dma_addr), .ic_read_dma_valid(ic_read_dma_valid),
        .tag_hit(tag_hit), .tag_miss(tag_miss),
        .tag_wea(tag_wea), .tag_addra(tag_addra), .tag_dina(tag_dina), .tag_addrb(tag_addrb),
        .ram_wea(ram_wea), .ram_addra(ram_addra), .ram_dina(ram_dina), .ram_addrb(ram_addrb)
    );

    always #5 clk = ~clk;

    // external RAMs: write port a, registered 2-stage read on port b
    logic         mem_clr = 1'b0;
    logic [19:0]  tmem [512];
    logic [127:0] dmem [512];
    logic [19:0]  t_p1;
    logic [127:0] d_p1;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 512; i++) begin
                tmem[i] <= '0;
                dmem[i] <= '0;
            end
        end else begin
            if (tag_wea) tmem[tag_addra] <= tag_dina;
            if (ram_wea) dmem[ram_addra] <= ram_dina;
        end
        t_p1      <= tmem[tag_addrb];
        tag_doutb <= t_p1;
        d_p1      <= dmem[ram_addrb];
        ram_doutb <= d_p1;
    end

    logic any_out;
    assign any_out = |{ic_data, cpu_read_ack, ic_read_dma_addr, ic_read_dma_valid, tag_hit,
                       tag_miss, tag_wea, tag_addra, tag_dina, tag_addrb, ram_wea, ram_addra,
                       ram_dina, ram_addrb};

    // reference cache: which line each index holds
    bit   [511:0] mvalid;
    logic [19:0]  mtag [512];
    logic [19:0]  tag_pool [6];

    function automatic logic [127:0] mem_fn(input logic [32:0] a);
        return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0], a[31:0] + 32'h0101_0101, {3'b101, a[32:4]}};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_preload(input logic [32:0] fa);
`ifdef IC_PRELOAD_EN
        logic [32:0] la;
        la = {fa[32:4], 4'h0};
        for (int k = 0; k < 2; k++) begin
            tick;
            check_eq("pl_req", {ic_read_dma_valid, ic_read_dma_addr}, {1'b1, la});
            repeat ($urandom_range(0, 2)) begin
                tick;
                check_eq("pl_hold", {ic_read_dma_valid, ic_read_dma_addr}, {1'b1, la});
            end
            ic_read_dma_ack  = 1'b1;
            ic_read_dma_data = mem_fn(la);
            tick;
            ic_read_dma_ack  = 1'b0;
            ic_read_dma_data = {4{$urandom}};
            check_eq("pl_strobes", {ic_read_dma_valid, ram_wea, tag_wea, cpu_read_ack}, 4'b0110);
            check_eq("pl_addra", {ram_addra, tag_addra}, {la[12:4], la[12:4]});
            check_eq("pl_tag", tag_dina, la[32:13]);
            check_eq("pl_data", ram_dina, mem_fn(la));
            mvalid[la[12:4]] = 1'b1;
            mtag[la[12:4]]   = la[32:13];
            la = la + 33'h10;
        end
        tick;
        check_eq("pl_done", {ic_read_dma_valid, ram_wea, cpu_read_ack}, 3'b000);
`else
        tick;
        check_eq("nopl_idle", {ic_read_dma_valid, ram_wea, cpu_read_ack}, 3'b000);
        tick;
        check_eq("nopl_idle2", ic_read_dma_valid, 1'b0);
`endif
    endtask

    // request already sampled at the last edge (E0); run it to completion
    task automatic serve(input logic [32:0] a, input bit inject, input logic [32:0] a2);
        logic [8:0]  idx;
        logic [19:0] tg;
        logic [32:0] line;
        bit          hit;
        int          d;
        idx  = a[12:4];
        tg   = a[32:13];
        line = {a[32:4], 4'h0};
        hit  = mvalid[idx] && (mtag[idx] == tg);
        repeat (3) tick;
        check_eq("early", {cpu_read_ack, tag_hit, tag_miss, ic_read_dma_valid}, 4'b0000);
        tick;
        if (hit) begin
            check_eq("hit_flags", {tag_hit, cpu_read_ack, tag_miss, ic_read_dma_valid}, 4'b1100);
            check_eq("hit_data", ic_data, mem_fn(line));
            tick;
            check_eq("hit_pulse", {tag_hit, cpu_read_ack}, 2'b00);
        end else begin
            check_eq("miss_flags", {tag_miss, tag_hit, cpu_read_ack, ic_read_dma_valid}, 4'b1001);
            check_eq("miss_addr", ic_read_dma_addr, line);
            d = inject ? $urandom_range(2, 3) : $urandom_range(0, 3);
            for (int i = 0; i < d; i++) begin
                if (inject && i == 0) begin
                    cpu_read_valid = 1'b1;
                    cpu_read_addr  = JUNK_ADDR;
                end else if (inject && i == 1) begin
                    cpu_read_valid = 1'b1;
                    cpu_read_addr  = a2;
                end
                tick;
                cpu_read_valid = 1'b0;
                check_eq("dma_hold", {tag_miss, ic_read_dma_valid, ic_read_dma_addr}, {2'b01, line});
            end
            ic_read_dma_ack  = 1'b1;
            ic_read_dma_data = mem_fn(line);
            tick;
            ic_read_dma_ack  = 1'b0;
            ic_read_dma_data = {4{$urandom}};
            check_eq("rf_strobes", {ic_read_dma_valid, ram_wea, tag_wea, cpu_read_ack}, 4'b0111);
            check_eq("rf_addra", {ram_addra, tag_addra}, {idx, idx});
            check_eq("rf_tag", tag_dina, tg);
            check_eq("rf_wdata", ram_dina, mem_fn(line));
            check_eq("rf_data", ic_data, mem_fn(line));
            mvalid[idx] = 1'b1;
            mtag[idx]   = tg;
            tick;
            check_eq("rf_pulse", {ram_wea, tag_wea, cpu_read_ack, tag_miss}, 4'b0000);
            check_eq("data_hold", ic_data, mem_fn(line));
        end
    endtask

    task automatic req(input logic [32:0] a, input bit inject, input logic [32:0] a2);
        bit will_miss;
        will_miss = !(mvalid[a[12:4]] && (mtag[a[12:4]] == a[32:13]));
        cpu_read_valid = 1'b1;
        cpu_read_addr  = a;
        tick;
        cpu_read_valid = 1'b0;
        cpu_read_addr  = {1'b0, $urandom};
        serve(a, inject && will_miss, a2);
        if (inject && will_miss) serve(a2, 1'b0, 33'h0);
    endtask

    function automatic logic [32:0] rand_addr();
        logic [8:0] idx;
        int sel;
        sel = $urandom_range(0, 9);
        idx = (sel == 8) ? 9'd511 : (sel == 9) ? 9'd5 : 9'(sel);
        return {tag_pool[$urandom_range(0, 5)], idx, 4'($urandom)};
    endfunction

    task automatic random_phase(input int n);
        for (int r = 0; r < n; r++) begin
            repeat ($urandom_range(0, 2)) tick;
            if ($urandom_range(0, 4) == 0) begin
                ic_read_dma_ack  = 1'b1;
                ic_read_dma_data = {4{$urandom}};
                tick;
                ic_read_dma_ack  = 1'b0;
                check_eq("stray_ack", {ic_read_dma_valid, ram_wea, cpu_read_ack}, 3'b000);
            end
            req(rand_addr(), ($urandom_range(0, 3) == 0), rand_addr());
        end
    endtask

    initial begin
        tag_pool = '{20'h0, 20'h1, 20'h2, 20'h3, 20'h80000, 20'h80001};
        rst = 1'b1;
        cpu_read_valid   = 1'b0;
        cpu_read_addr    = '0;
        first_addr       = '0;
        ic_read_dma_ack  = 1'b0;
        ic_read_dma_data = '0;
        mvalid = '0;
        for (int i = 0; i < 512; i++) mtag[i] = '0;
        mem_clr = 1'b1;
        tick;
        tick;
        mem_clr = 1'b0;
        check_eq("rst_outs", any_out, 1'b0);
        rst = 1'b0;
        run_preload(33'h0);

        req(33'h0, 1'b0, 33'h0);
        req(33'h2000, 1'b0, 33'h0);
        req(33'h50, 1'b0, 33'h0);
        req(33'h0, 1'b0, 33'h0);
        req(33'h3000, 1'b1, 33'h2004);
        random_phase(60);

        // reset in the middle of a refill, with a request pending
        cpu_read_valid = 1'b1;
        cpu_read_addr  = {20'hABCDE, 9'd100, 4'h0};
        tick;
        cpu_read_valid = 1'b0;
        repeat (4) tick;
        check_eq("rr_refill", {tag_miss, ic_read_dma_valid}, 2'b11);
        cpu_read_valid = 1'b1;
        cpu_read_addr  = {20'h1, 9'd3, 4'h0};
        tick;
        cpu_read_valid = 1'b0;
        first_addr = 33'h1_0000_1FF7;
        rst = 1'b1;
        tick;
        check_eq("rr_outs", any_out, 1'b0);
        mvalid = '0;
        rst = 1'b0;
        run_preload(first_addr);
        repeat (6) begin
            tick;
            check_eq("pend_drop", {cpu_read_ack, tag_hit, tag_miss, ic_read_dma_valid}, 4'b0000);
        end
        req(33'h1_0000_1FF0, 1'b0, 33'h0);
        req(33'h1_0000_2008, 1'b0, 33'h0);
        random_phase(60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
